// File: rtl/timestamp_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : timestamp_packetizer
//  Description : Reads a verified snapshot of a two-channel timestamp latch
//                and serialises it as a 13-byte packet on a valid/ready byte
//                stream, then pulses the channel latch reset until its ready
//                flag drops.
//  Revision    : 1.0  initial release
// ============================================================================
module timestamp_packetizer #(
    parameter logic [7:0] pHEADER      = 8'hA0,
    parameter int         pSYNC_STAGES = 2
) (
    input  logic        globalClock,
    input  logic        iRst_n,
    input  logic        iRdy1,
    input  logic        iRdy2,
    input  logic [31:0] i1Lo,
    input  logic [31:0] i1Hi,
    input  logic [31:0] i1Phase,
    input  logic [31:0] i2Lo,
    input  logic [31:0] i2Hi,
    input  logic [31:0] i2Phase,
    output logic [7:0]  oData,
    output logic        oValid,
    input  logic        iReady,
    output logic        oResetLatch1,
    output logic        oResetLatch2,
    output logic        oBusy,
    output logic [7:0]  oMismatchCnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_VERIFY  = 3'd2,
        S_SEND    = 3'd3,
        S_ACK     = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [pSYNC_STAGES-1:0] r_sync1;
    logic [pSYNC_STAGES-1:0] r_sync2;
    logic                    r_ch;       // 0 = channel 1, 1 = channel 2
    logic                    r_pri;
    logic [2:0]              r_seq;
    logic [3:0]              r_idx;
    logic [89:0]             r_shadow;   // {phase[25:0], hi, lo}
    logic [7:0]              r_mm;
    logic                    r_valid;
    logic [7:0]              r_data;
    logic                    r_latch1;
    logic                    r_latch2;
    logic                    r_busy;

    logic                    w_srdy1;
    logic                    w_srdy2;
    logic                    w_srdy_sel;
    logic                    w_sel_ch;
    logic                    w_accept;
    logic                    w_last;
    logic [3:0]              w_idx_nxt;
    logic [89:0]             w_live;
    logic [103:0]            w_pkt;
    logic                    w_unused_phase;

    assign w_srdy1    = r_sync1[pSYNC_STAGES-1];
    assign w_srdy2    = r_sync2[pSYNC_STAGES-1];
    assign w_srdy_sel = r_ch ? w_srdy2 : w_srdy1;
    assign w_accept   = r_valid && iReady;
    assign w_last     = (r_idx == 4'd12);
    assign w_idx_nxt  = r_idx + 4'd1;

    // Live view of the selected channel, in the same layout as the shadow
    assign w_live = r_ch ? {i2Phase[25:0], i2Hi, i2Lo}
                         : {i1Phase[25:0], i1Hi, i1Lo};

    // Whole packet, byte 0 in the low bits; multi-byte fields little-endian
    assign w_pkt = {6'b0, r_shadow[89:64], r_shadow[63:32], r_shadow[31:0],
                    pHEADER[7:4], r_seq, r_ch};

    // Top phase bits carry nothing for this block
    assign w_unused_phase = ^{i1Phase[31:26], i2Phase[31:26]};

    // Ready flag synchronisers
    always_ff @(posedge globalClock) begin
        if (!iRst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {r_sync1[pSYNC_STAGES-2:0], iRdy1};
            r_sync2 <= {r_sync2[pSYNC_STAGES-2:0], iRdy2};
        end
    end

    // State register
    always_ff @(posedge globalClock) begin
        if (!iRst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decision and channel arbitration
    always_comb begin
        w_next   = r_state;
        w_sel_ch = r_pri;
        case (r_state)
            S_IDLE: begin
                if (w_srdy1 && w_srdy2) begin
                    w_sel_ch = r_pri;
                    w_next   = S_CAPTURE;
                end else if (w_srdy1) begin
                    w_sel_ch = 1'b0;
                    w_next   = S_CAPTURE;
                end else if (w_srdy2) begin
                    w_sel_ch = 1'b1;
                    w_next   = S_CAPTURE;
                end
            end
            S_CAPTURE: w_next = S_VERIFY;
            S_VERIFY:  w_next = (w_live == r_shadow) ? S_SEND : S_CAPTURE;
            S_SEND:    if (w_accept && w_last) w_next = S_ACK;
            S_ACK:     if (!w_srdy_sel) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Datapath: snapshot, byte stream, latch reset and bookkeeping
    always_ff @(posedge globalClock) begin
        if (!iRst_n) begin
            r_ch     <= 1'b0;
            r_pri    <= 1'b0;
            r_seq    <= 3'd0;
            r_idx    <= 4'd0;
            r_shadow <= '0;
            r_mm     <= 8'h00;
            r_valid  <= 1'b0;
            r_data   <= 8'h00;
            r_latch1 <= 1'b0;
            r_latch2 <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_CAPTURE) r_ch <= w_sel_ch;
                end
                S_CAPTURE: begin
                    r_shadow <= w_live;
                end
                S_VERIFY: begin
                    if (w_next == S_SEND) begin
                        r_idx   <= 4'd0;
                        r_valid <= 1'b1;
                        r_data  <= w_pkt[7:0];
                    end else if (r_mm != 8'hFF) begin
                        r_mm <= r_mm + 8'd1;
                    end
                end
                S_SEND: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_valid  <= 1'b0;
                            r_idx    <= 4'd0;
                            r_latch1 <= !r_ch;
                            r_latch2 <= r_ch;
                        end else begin
                            r_idx  <= w_idx_nxt;
                            r_data <= w_pkt[{w_idx_nxt, 3'b000} +: 8];
                        end
                    end
                end
                S_ACK: begin
                    if (w_next == S_IDLE) begin
                        r_latch1 <= 1'b0;
                        r_latch2 <= 1'b0;
                        r_seq    <= r_seq + 3'd1;
                        r_pri    <= !r_ch;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oData        = r_data;
    assign oValid       = r_valid;
    assign oResetLatch1 = r_latch1;
    assign oResetLatch2 = r_latch2;
    assign oBusy        = r_busy;
    assign oMismatchCnt = r_mm;

endmodule
`default_nettype wire

// File: tb/tb_timestamp_packetizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_timestamp_packetizer
//  Description : Self-checking bench for timestamp_packetizer with a
//                packet-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timestamp_packetizer;

    logic        globalClock = 1'b0;
    logic        iRst_n;
    logic        iRdy1, iRdy2;
    logic [31:0] i1Lo, i1Hi, i1Phase, i2Lo, i2Hi, i2Phase;
    logic [7:0]  oData;
    logic        oValid;
    logic        iReady;
    logic        oResetLatch1, oResetLatch2, oBusy;
    logic [7:0]  oMismatchCnt;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: packet sequence, round-robin owner, error count
    int m_seq;
    int m_pri;
    int m_cnt;

    timestamp_packetizer dut (
        .globalClock  (globalClock),
        .iRst_n       (iRst_n),
        .iRdy1        (iRdy1),
        .iRdy2        (iRdy2),
        .i1Lo         (i1Lo),
        .i1Hi         (i1Hi),
        .i1Phase      (i1Phase),
        .i2Lo         (i2Lo),
        .i2Hi         (i2Hi),
        .i2Phase      (i2Phase),
        .oData        (oData),
        .oValid       (oValid),
        .iReady       (iReady),
        .oResetLatch1 (oResetLatch1),
        .oResetLatch2 (oResetLatch2),
        .oBusy        (oBusy),
        .oMismatchCnt (oMismatchCnt)
    );

    always #5 globalClock = ~globalClock;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected packet byte i for channel ch, from the current channel inputs
    function automatic logic [7:0] exp_byte(input int ch, input int i);
        logic [31:0] lo, hi, ph;
        lo = (ch == 1) ? i1Lo : i2Lo;
        hi = (ch == 1) ? i1Hi : i2Hi;
        ph = ((ch == 1) ? i1Phase : i2Phase) & 32'h03FF_FFFF;
        if (i == 0)      return {4'hA, 3'(m_seq), 1'(ch == 2)};
        else if (i <= 4) return 8'(lo >> (8 * (i - 1)));
        else if (i <= 8) return 8'(hi >> (8 * (i - 5)));
        else             return 8'(ph >> (8 * (i - 9)));
    endfunction

    task automatic set_rdy(input int ch, input logic v);
        if (ch == 1) iRdy1 = v;
        else         iRdy2 = v;
    endtask

    task automatic rand_data(input int ch);
        if (ch == 1) begin
            i1Lo = $urandom; i1Hi = $urandom; i1Phase = $urandom;
        end else begin
            i2Lo = $urandom; i2Hi = $urandom; i2Phase = $urandom;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, oValid, 0);
        check_val({tag, "_data"}, oData, 0);
        check_val({tag, "_latch1"}, oResetLatch1, 0);
        check_val({tag, "_latch2"}, oResetLatch2, 0);
        check_val({tag, "_busy"}, oBusy, 0);
        check_val({tag, "_mmcnt"}, oMismatchCnt, 0);
    endtask

    task automatic do_reset();
        iRst_n = 1'b0;
        @(negedge globalClock);
        check_reset_outputs("reset");
        @(negedge globalClock);
        iRst_n = 1'b1;
        m_seq = 0; m_pri = 0; m_cnt = 0;
    endtask

    // Called right after a ready flag was raised at a falling edge; counts
    // rising edges after the first sampling edge until the header appears.
    task automatic wait_header(input int exp_lat);
        int lat;
        lat = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge globalClock);
            lat++;
            if (oValid) break;
        end
        if (!oValid) check_val("header_timeout", 0, 1);
        else if (exp_lat >= 0) check_val("latency", lat, exp_lat);
        check_val("busy_sending", oBusy, 1);
    endtask

    // Receive a whole packet, then run the latch-reset handshake
    task automatic recv_and_ack(input int ch, input bit bp);
        int         n, cyc, e;
        bit         stalled;
        logic [7:0] held;
        n = 0; cyc = 0; stalled = 0; held = 8'h00;
        while (n < 13 && cyc < 3000) begin
            if (stalled) begin
                check_val("stall_valid", oValid, 1);
                check_val("stall_data", oData, held);
            end
            if (oValid) begin
                iReady = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                check_val($sformatf("ch%0d_byte%0d", ch, n), oData, exp_byte(ch, n));
                if (iReady) begin
                    n++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held    = oData;
                end
            end
            @(negedge globalClock);
            cyc++;
        end
        iReady = 1'b1;
        if (n < 13) check_val("rx_timeout", n, 13);
        check_val("valid_after_pkt", oValid, 0);
        check_val("latch_rise", (ch == 1) ? oResetLatch1 : oResetLatch2, 1);
        check_val("latch_other", (ch == 1) ? oResetLatch2 : oResetLatch1, 0);
        check_val("busy_ack", oBusy, 1);
        repeat ($urandom_range(0, 3)) begin
            @(negedge globalClock);
            check_val("latch_hold", (ch == 1) ? oResetLatch1 : oResetLatch2, 1);
        end
        set_rdy(ch, 1'b0);
        e = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge globalClock);
            e++;
            if (((ch == 1) ? oResetLatch1 : oResetLatch2) == 1'b0) break;
        end
        check_val("latch_fall_edges", e, 3);
        m_seq = (m_seq + 1) % 8;
        m_pri = (ch == 1) ? 1 : 0;
    endtask

    // Raise one or both channels together and serve them in model order
    task automatic serve(input bit use1, input bit use2, input bit bp);
        int first;
        if (use1) begin rand_data(1); iRdy1 = 1'b1; end
        if (use2) begin rand_data(2); iRdy2 = 1'b1; end
        if (use1 && use2) first = (m_pri == 0) ? 1 : 2;
        else              first = use1 ? 1 : 2;
        wait_header(4);
        recv_and_ack(first, bp);
        if (use1 && use2) begin
            wait_header(-1);
            recv_and_ack((first == 1) ? 2 : 1, bp);
        end
    endtask

    initial begin
        iRst_n = 1'b0; iRdy1 = 1'b0; iRdy2 = 1'b0; iReady = 1'b1;
        i1Lo = '0; i1Hi = '0; i1Phase = '0; i2Lo = '0; i2Hi = '0; i2Phase = '0;
        @(negedge globalClock);
        do_reset();

        // Single packet with the reference values
        i1Lo = 32'h04030201; i1Hi = 32'h08070605; i1Phase = 32'h0C0B0A09;
        iRdy1 = 1'b1;
        wait_header(4);
        recv_and_ack(1, 1'b0);

        // Same packet under random backpressure
        iRdy1 = 1'b1;
        wait_header(4);
        recv_and_ack(1, 1'b1);

        // Simultaneous pair, a lone ch1 packet, then another pair
        serve(1'b1, 1'b1, 1'b0);
        serve(1'b1, 1'b0, 1'b0);
        serve(1'b1, 1'b1, 1'b1);

        // Unstable data: two mismatches before the value settles
        begin
            int lat;
            rand_data(1);
            iRdy1 = 1'b1;
            lat = -1;
            for (int c = 0; c < 60; c++) begin
                @(negedge globalClock);
                lat++;
                if (lat == 3) i1Lo = i1Lo ^ 32'h0000_0100;
                if (lat == 5) i1Lo = 32'hDEADBEEF;
                if (oValid) break;
            end
            check_val("mismatch_latency", lat, 8);
            m_cnt = m_cnt + 2;
            check_val("mismatch_cnt", oMismatchCnt, m_cnt);
            recv_and_ack(1, 1'b0);
        end

        // Continuously changing data drives the counter into saturation
        begin
            rand_data(1);
            iRdy1 = 1'b1;
            for (int c = 0; c < 700; c++) begin
                @(negedge globalClock);
                i1Lo = ~i1Lo;
            end
            check_val("no_send_unstable", oValid, 0);
            m_cnt = (m_cnt + 300 > 255) ? 255 : m_cnt + 300;
            wait_header(-1);
            check_val("mismatch_sat", oMismatchCnt, m_cnt);
            recv_and_ack(1, 1'b0);
        end

        // Reset in the middle of a ch2 packet
        rand_data(2);
        iRdy2 = 1'b1;
        wait_header(4);
        for (int b = 0; b < 6; b++) begin
            check_val($sformatf("pre_reset_byte%0d", b), oData, exp_byte(2, b));
            @(negedge globalClock);
        end
        iRst_n = 1'b0;
        @(negedge globalClock);
        check_reset_outputs("midpkt");
        m_seq = 0; m_pri = 0; m_cnt = 0;
        @(negedge globalClock);
        iRst_n = 1'b1;
        wait_header(4);
        check_val("post_reset_header", oData, 8'hA1);
        recv_and_ack(2, 1'b0);

        // Sequence wrap over nine ch1 packets
        do_reset();
        for (int p = 0; p < 9; p++) serve(1'b1, 1'b0, 1'($urandom_range(0, 1)));

        // Random mix of channels and backpressure
        for (int r = 0; r < 8; r++) begin
            int sel;
            sel = $urandom_range(1, 3);
            serve(1'(sel != 2), 1'(sel != 1), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
